// File: rtl/hs32_mem_arbiter_if.sv
// Bus bundle for the HS32 memory arbiter: fetch and execute requester handshakes plus the shared memory port.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface hs32_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] addrf;
  logic              reqf;
  logic              ackf;
  logic [DATA_W-1:0] dtrf;
  logic              flush;
  logic [ADDR_W-1:0] addre;
  logic [DATA_W-1:0] dtwe;
  logic              rwe;
  logic              reqe;
  logic              acke;
  logic [DATA_W-1:0] dtre;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_dtw;
  logic              mem_rw;
  logic              mem_valid;
  logic [DATA_W-1:0] mem_dtr;
  logic              mem_ready;

  modport slave (
    input  addrf, reqf, flush, addre, dtwe, rwe, reqe, mem_dtr, mem_ready,
    output ackf, dtrf, acke, dtre, mem_addr, mem_dtw, mem_rw, mem_valid
  );

  modport master (
    output addrf, reqf, flush, addre, dtwe, rwe, reqe, mem_dtr, mem_ready,
    input  ackf, dtrf, acke, dtre, mem_addr, mem_dtw, mem_rw, mem_valid
  );
endinterface

// File: rtl/hs32_mem_arbiter.sv
// Serialises fetch (read-only) and execute (load/store) requests onto one registered memory port.
// Define HS32_ARB_RR_EN for round-robin on simultaneous requests; otherwise execute always wins.
//
// state | meaning
// IDLE  | arbitrating; no transfer outstanding
// BUSF  | fetch owns the bus, waiting for mem_ready
// BUSE  | execute owns the bus, waiting for mem_ready
// ACK   | one-cycle ack pulse to the owner
module hs32_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  hs32_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSF, BUSE, ACK} state_t;

  state_t            state_q, state_d;
  logic              owner_e_q, owner_e_d;
  logic              drop_q, drop_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_dtw_q, mem_dtw_d;
  logic              mem_rw_q, mem_rw_d;
  logic              mem_valid_q, mem_valid_d;
  logic [DATA_W-1:0] dtrf_q, dtrf_d;
  logic [DATA_W-1:0] dtre_q, dtre_d;

  logic fetch_ok;
  logic grant_e;
  logic grant_f;

  assign fetch_ok = bus.reqf & ~bus.flush;

`ifdef HS32_ARB_RR_EN
  // last_e_q = 1 when execute owned the previous transfer; on a tie the other side wins
  logic last_e_q, last_e_d;

  assign grant_e  = bus.reqe & (~fetch_ok | ~last_e_q);
  assign last_e_d = ((state_q == IDLE) && (grant_e || grant_f)) ? grant_e : last_e_q;

  always_ff @(posedge clk) begin
    if (reset) last_e_q <= 1'b0;
    else       last_e_q <= last_e_d;
  end
`else
  assign grant_e = bus.reqe;
`endif

  assign grant_f = fetch_ok & ~grant_e;

  always_comb begin
    state_d     = state_q;
    owner_e_d   = owner_e_q;
    drop_d      = drop_q;
    mem_addr_d  = mem_addr_q;
    mem_dtw_d   = mem_dtw_q;
    mem_rw_d    = mem_rw_q;
    mem_valid_d = mem_valid_q;
    dtrf_d      = dtrf_q;
    dtre_d      = dtre_q;
    case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if (grant_e) begin
          state_d     = BUSE;
          owner_e_d   = 1'b1;
          mem_addr_d  = bus.addre;
          mem_dtw_d   = bus.dtwe;
          mem_rw_d    = bus.rwe;
          mem_valid_d = 1'b1;
        end else if (grant_f) begin
          state_d     = BUSF;
          owner_e_d   = 1'b0;
          mem_addr_d  = bus.addrf;
          mem_dtw_d   = '0;
          mem_rw_d    = 1'b0;
          mem_valid_d = 1'b1;
        end
      end
      BUSF, BUSE: begin
        // the bus cannot be aborted, so a flush only marks the fetch result as dead
        if (state_q == BUSF && bus.flush) drop_d = 1'b1;
        if (bus.mem_ready) begin
          mem_valid_d = 1'b0;
          state_d     = ACK;
          if (!owner_e_q)     dtrf_d = bus.mem_dtr;
          else if (!mem_rw_q) dtre_d = bus.mem_dtr;
        end
      end
      ACK: begin
        state_d = IDLE;
        drop_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_e_q   <= 1'b0;
      drop_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_dtw_q   <= '0;
      mem_rw_q    <= 1'b0;
      mem_valid_q <= 1'b0;
      dtrf_q      <= '0;
      dtre_q      <= '0;
    end else begin
      state_q     <= state_d;
      owner_e_q   <= owner_e_d;
      drop_q      <= drop_d;
      mem_addr_q  <= mem_addr_d;
      mem_dtw_q   <= mem_dtw_d;
      mem_rw_q    <= mem_rw_d;
      mem_valid_q <= mem_valid_d;
      dtrf_q      <= dtrf_d;
      dtre_q      <= dtre_d;
    end
  end

  assign bus.ackf      = (state_q == ACK) & ~owner_e_q & ~drop_q;
  assign bus.acke      = (state_q == ACK) & owner_e_q;
  assign bus.dtrf      = dtrf_q;
  assign bus.dtre      = dtre_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_dtw   = mem_dtw_q;
  assign bus.mem_rw    = mem_rw_q;
  assign bus.mem_valid = mem_valid_q;

endmodule
